regfile_read_scoreboard: RTL
============================

// Module: regfile_read_scoreboard
// PURPOSE
//   Read side of the superscalar architectural register state. Holds NREG x DATA_W registers
//   written by two writeback ports, and serves four registered read ports (two per issue slot).
//   Tracks a busy bit per register so issue logic knows whether an operand is available.
//   Sits between dispatch (alloc), the writeback stage (wr0/wr1) and operand fetch (rd0..rd3).
// PARAMETERS
//   DATA_W  16  register width
//   NREG    8   number of architectural registers (R0..R7)
//   AW      3   register address width, clog2(NREG)
// PORTS
//   clock        in   1        single clock, all state updates on posedge
//   reset        in   1        asynchronous, active-low (reset==0 clears all state)
//   wr_en0       in   1        writeback port 0 enable (older instruction)
//   wr_addr0     in   AW       writeback port 0 register
//   wr_data0     in   DATA_W   writeback port 0 data
//   wr_en1       in   1        writeback port 1 enable (younger instruction)
//   wr_addr1     in   AW       writeback port 1 register
//   wr_data1     in   DATA_W   writeback port 1 data
//   alloc_en0    in   1        dispatch slot 0 claims a destination register
//   alloc_addr0  in   AW       dispatch slot 0 destination
//   alloc_en1    in   1        dispatch slot 1 claims a destination register
//   alloc_addr1  in   AW       dispatch slot 1 destination
//   rd_req       in   4        per-port read request, bit k for port k
//   rd_addr0..3  in   AW       read addresses, one per port
//   rd_data0..3  out  DATA_W   registered read data
//   rd_valid0..3 out  1        registered: operand value is final (not pending)
//   busy         out  NREG     current busy bit per register
// BEHAVIOUR
//   Reset (reset==0, asynchronous): all registers=0, busy=0, rd_data*=0, rd_valid*=0.
//     Reset takes effect mid-operation; in-flight reads are discarded.
//   Write: on posedge, wr_enK writes wr_dataK into reg[wr_addrK].
//     Same address on both ports: port 1 value is stored.
//   Busy update on posedge, per register r, in priority order:
//     1. alloc_en1 && alloc_addr1==r      -> busy[r]=1
//     2. alloc_en0 && alloc_addr0==r      -> busy[r]=1
//     3. (wr_en0||wr_en1) hits r          -> busy[r]=0
//     4. otherwise hold.
//     An alloc and a write to the same r in one cycle leave busy[r]=1 (new producer wins).
//   Read, 1-cycle latency: request in cycle N -> rd_dataK/rd_validK valid after edge N+1.
//     Source priority: wr1 match, then wr0 match (same-cycle bypass), then reg[rd_addrK].
//     rd_validK = 1 if the value is bypassed from a write in cycle N,
//       else !busy[rd_addrK] sampled in cycle N, before that cycle's allocs.
//       Same-cycle allocs never affect a read issued in the same cycle.
//     rd_req[K]==0: rd_validK <= 0 and rd_dataK holds its previous value.
//   All four ports are independent; any ports may read the same register.
//   busy output is the registered busy vector and is not bypassed.
//   Address range: NREG must equal 2**AW, so every address is valid; no wrap is needed.
// TESTING
//   1. Release reset, then read R0..R3 -> after 1 cycle rd_data*=0, rd_valid*=1, busy=8'h00.
//   2. wr0 R2=16'h1234; next cycle read R2 on port 0 -> rd_data0=16'h1234, rd_valid0=1.
//   3. Same cycle wr0 R5=16'hAAAA, wr1 R5=16'h5555, rd port1 R5 -> rd_data1=16'h5555, rd_valid1=1;
//      a later read of R5 also returns 16'h5555.
//   4. alloc0 R3, next cycle read R3 -> rd_valid=0, busy[3]=1; then wr1 R3=16'h00FF with a
//      same-cycle read R3 -> rd_data=16'h00FF, rd_valid=1, busy[3]=0 after the edge.
//   5. Same cycle alloc1 R4 + wr0 R4=16'h0F0F -> busy[4]=1, reg[4]=16'h0F0F, next read of R4
//      has rd_valid=0.
//   6. Drive reset=0 asynchronously mid-read with busy=8'hFF -> busy, rd_valid* and rd_data*
//      clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_read_scoreboard.sv
// regfile_read_scoreboard
// Architectural register file for a two-wide machine: two writeback ports,
// four registered read ports with same-cycle write bypass, and a per-register
// busy (pending producer) bit maintained from dispatch allocations and writebacks.
module regfile_read_scoreboard #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  // writeback port 0 (older instruction)
  input  logic              wr_en0_i,
  input  logic [AW-1:0]     wr_addr0_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  // writeback port 1 (younger instruction)
  input  logic              wr_en1_i,
  input  logic [AW-1:0]     wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  // dispatch destination claims
  input  logic              alloc_en0_i,
  input  logic [AW-1:0]     alloc_addr0_i,
  input  logic              alloc_en1_i,
  input  logic [AW-1:0]     alloc_addr1_i,
  // operand fetch
  input  logic [3:0]        rd_req_i,
  input  logic [AW-1:0]     rd_addr0_i,
  input  logic [AW-1:0]     rd_addr1_i,
  input  logic [AW-1:0]     rd_addr2_i,
  input  logic [AW-1:0]     rd_addr3_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic [DATA_W-1:0] rd_data3_o,
  output logic              rd_valid0_o,
  output logic              rd_valid1_o,
  output logic              rd_valid2_o,
  output logic              rd_valid3_o,
  output logic [NREG-1:0]   busy_o
);

  localparam int NPORT = 4;

  // Architectural state
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Read-port plumbing, gathered into arrays so the ports share one code path
  logic [AW-1:0]     rd_addr   [NPORT];
  logic [DATA_W-1:0] rd_data_d [NPORT];
  logic [DATA_W-1:0] rd_data_q [NPORT];
  logic [NPORT-1:0]  rd_valid_d;
  logic [NPORT-1:0]  rd_valid_q;

  assign rd_addr[0] = rd_addr0_i;
  assign rd_addr[1] = rd_addr1_i;
  assign rd_addr[2] = rd_addr2_i;
  assign rd_addr[3] = rd_addr3_i;

  // Register writes; port 1 is issued second so it wins on an address collision
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr_en0_i) regs_q[wr_addr0_i] <= wr_data0_i;
      if (wr_en1_i) regs_q[wr_addr1_i] <= wr_data1_i;
    end
  end

  // Next busy vector: writebacks clear, allocations set afterwards so a new
  // producer claimed in the same cycle as an older result keeps the bit set
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if ((wr_en0_i && (wr_addr0_i == AW'(r))) ||
          (wr_en1_i && (wr_addr1_i == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end
      if ((alloc_en0_i && (alloc_addr0_i == AW'(r))) ||
          (alloc_en1_i && (alloc_addr1_i == AW'(r)))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // Busy register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Operand source select per port: younger writeback, then older writeback,
  // then the stored value whose validity comes from the pre-alloc busy bit
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      rd_data_d[k]  = regs_q[rd_addr[k]];
      rd_valid_d[k] = ~busy_q[rd_addr[k]];
      if (wr_en0_i && (wr_addr0_i == rd_addr[k])) begin
        rd_data_d[k]  = wr_data0_i;
        rd_valid_d[k] = 1'b1;
      end
      if (wr_en1_i && (wr_addr1_i == rd_addr[k])) begin
        rd_data_d[k]  = wr_data1_i;
        rd_valid_d[k] = 1'b1;
      end
    end
  end

  // Read-port output registers; idle ports keep their data but drop valid
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NPORT; k++) begin
        rd_data_q[k] <= '0;
      end
      rd_valid_q <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (rd_req_i[k]) begin
          rd_data_q[k]  <= rd_data_d[k];
          rd_valid_q[k] <= rd_valid_d[k];
        end else begin
          rd_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign rd_data0_o  = rd_data_q[0];
  assign rd_data1_o  = rd_data_q[1];
  assign rd_data2_o  = rd_data_q[2];
  assign rd_data3_o  = rd_data_q[3];
  assign rd_valid0_o = rd_valid_q[0];
  assign rd_valid1_o = rd_valid_q[1];
  assign rd_valid2_o = rd_valid_q[2];
  assign rd_valid3_o = rd_valid_q[3];
  assign busy_o      = busy_q;

endmodule
